dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port 19-bit data memory. It shares that memory between the CPU memory-stage port (m0) and a DMA/debug loader port (m1). Arbitration is round-robin, with an optional bounded burst lock for m1. Each accepted access is issued to the memory through a registered stage, and the response returns with fixed latency, at one access per cycle.

## Interface
- AW, 19: address width
- DW, 19: data width
- DEPTH, 1025: number of valid memory words; valid addresses are 0..DEPTH-1
- MAX_LOCK, 8: maximum consecutive locked m1 beats while m0 is waiting
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- m0_valid / m1_valid  in  1  request present
- m0_ready / m1_ready  out  1  request accepted this cycle (valid & ready)
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  word address
- m0_wdata / m1_wdata  in  DW  write data
- m1_lock  in  1  request to keep the grant for following beats
- m0_rvalid / m1_rvalid  out  1  one-cycle response pulse, issued for reads and writes
- m0_rdata / m1_rdata  out  DW  read data; 0 for writes and errors
- m0_err / m1_err  out  1  qualifies rvalid; the address was >= DEPTH
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinational from mem_addr

## Operation
- Grant FSM states: ARB and LOCKED.
- ARB state:
  - If only one port is valid, that port gets ready.
  - If both are valid, the port that did not win last gets ready.
  - last_grant resets to m1, so m0 wins the first tie.
- ARB to LOCKED: an m1 beat is accepted with m1_lock=1.
- In LOCKED:
  - m1 keeps ready while m1_valid=1 and m1_lock=1.
  - lock_cnt increments on each accepted locked beat.
- LOCKED to ARB happens in any of these cases:
  - m1_valid=0 or m1_lock=0 in a cycle.
  - lock_cnt reaches MAX_LOCK while m0_valid=1. The next grant is then forced to m0 for exactly one beat.
- lock_cnt clears on every exit from LOCKED.
- At most one port is ready in any cycle. ready never depends on that port's own valid, except through the arbitration decision.
- Accepted request fields (port id, we, addr, wdata, err = addr >= DEPTH) are captured in an issue register.
- Issue stage:
  - mem_addr = issued addr; mem_wdata = issued wdata.
  - mem_we = issue_valid & we & ~err.
  - An out-of-range write is dropped and never reaches memory. An out-of-range read does not use mem_rdata.
- The response register captures rdata (mem_rdata for valid reads, else 0), err and port id. It drives rvalid on the originating port only.
- No backpressure exists on responses. Issue and response stages advance every cycle.

## Timing
- Request accepted at rising edge N (valid & ready in cycle N-1).
- Issue stage: cycle N; the memory write takes effect at edge N+1.
- Response: rvalid/rdata/err valid during cycle N+1, for exactly one cycle.
- Throughput is 1 access per cycle, across both ports combined.
- Read-after-write: a read accepted one cycle after a write to the same address returns the new data.
- Reset values:
  - All ready, rvalid, err and mem_we are 0.
  - rdata, mem_addr and mem_wdata are 0.
  - State is ARB, lock_cnt = 0, last_grant = m1.
- rst asserted mid-operation:
  - In-flight issue and response stages are discarded; no rvalid follows reset, and no write is committed from a discarded issue.
  - The lock is released.
- Address exactly DEPTH-1 (1024) is valid. DEPTH (1025) and above set err.

## Test plan
- Single read: m0 reads addr 2 (memory holds 0x0000F); accepted at edge N -> m0_rvalid=1, m0_rdata=0x0000F, m0_err=0 during cycle N+1; m1_rvalid stays 0.
- Contention: both ports request reads every cycle for 6 cycles after reset -> grants alternate m0, m1, m0, m1, m0, m1; responses arrive 1 cycle after each grant on the matching port.
- Write then read: m1 writes 0x12345 to addr 10, then reads addr 10 on the next cycle -> mem_we pulses once with mem_addr=10; the read response is 0x12345.
- Lock bound: m1 issues 12 locked beats while m0_valid is held high -> m1 gets 8 consecutive beats, then m0 gets 1 beat, then m1 gets 4 more in a new locked burst (lock re-entered on the next beat).
- Out of range: m0 writes 0x7FFFF to addr 1025, then reads addr 1025 -> mem_we never asserts; both responses have err=1 and rdata=0.
- Reset mid-flight: assert rst in the cycle after a read is accepted -> no rvalid follows; outputs are 0 while rst=1; the first tie after release is granted to m0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Brief    : Request/response bundle for the two arbiter ports plus the
//             single-port data memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 19
);
    logic          m0_valid;
    logic          m0_ready;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m0_err;

    logic          m1_valid;
    logic          m1_ready;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          m1_err;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  m0_valid, m0_we, m0_addr, m0_wdata,
        output m0_ready, m0_rvalid, m0_rdata, m0_err,
        input  m1_valid, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_ready, m1_rvalid, m1_rdata, m1_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requestor / memory-model side
    modport master (
        output m0_valid, m0_we, m0_addr, m0_wdata,
        input  m0_ready, m0_rvalid, m0_rdata, m0_err,
        output m1_valid, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_ready, m1_rvalid, m1_rdata, m1_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Round-robin two-port arbiter with bounded m1 burst lock in
//             front of a single-port data memory; fixed one-cycle response.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW       = 19,
    parameter int DW       = 19,
    parameter int DEPTH    = 1025,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int            CW         = $clog2(MAX_LOCK + 1);
    localparam logic [AW-1:0] C_DEPTH    = AW'(DEPTH);
    localparam logic [CW-1:0] C_MAX_LOCK = CW'(MAX_LOCK);
    localparam logic [CW-1:0] C_ONE      = CW'(1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          last_grant_q, last_grant_d;   // 0 = m0, 1 = m1
    logic          gnt0, gnt1, lock_hold;

    // Grant FSM: next state and ready decisions
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        lock_hold    = (state_q == ST_LOCKED) && bus.m1_valid && bus.m1_lock &&
                       !((lock_cnt_q >= C_MAX_LOCK) && bus.m0_valid);
        if (!rst) begin
            if (lock_hold) begin
                gnt1 = 1'b1;
                if (lock_cnt_q != C_MAX_LOCK) begin
                    lock_cnt_d = lock_cnt_q + C_ONE;
                end
            end else begin
                // Plain round-robin; on a bound-triggered release last_grant is m1,
                // so a waiting m0 takes exactly this beat.
                if (bus.m0_valid && (!bus.m1_valid || last_grant_q)) begin
                    gnt0 = 1'b1;
                end else if (bus.m1_valid) begin
                    gnt1 = 1'b1;
                end
                state_d    = ST_ARB;
                lock_cnt_d = '0;
                if (gnt1 && bus.m1_lock) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = C_ONE;
                end
            end
            if (gnt0) begin
                last_grant_d = 1'b0;
            end else if (gnt1) begin
                last_grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ARB;
            lock_cnt_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.m0_ready = gnt0;
    assign bus.m1_ready = gnt1;

    logic          accept;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    assign accept    = gnt0 | gnt1;
    assign req_we    = gnt1 ? bus.m1_we    : bus.m0_we;
    assign req_addr  = gnt1 ? bus.m1_addr  : bus.m0_addr;
    assign req_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;

    logic          iss_valid_q, iss_port_q, iss_we_q, iss_err_q;
    logic [AW-1:0] iss_addr_q;
    logic [DW-1:0] iss_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_port_q  <= 1'b0;
            iss_we_q    <= 1'b0;
            iss_err_q   <= 1'b0;
            iss_addr_q  <= '0;
            iss_wdata_q <= '0;
        end else begin
            iss_valid_q <= accept;
            if (accept) begin
                iss_port_q  <= gnt1;
                iss_we_q    <= req_we;
                iss_err_q   <= (req_addr >= C_DEPTH);
                iss_addr_q  <= req_addr;
                iss_wdata_q <= req_wdata;
            end
        end
    end

    // Out-of-range writes never strobe the memory
    assign bus.mem_we    = !rst && iss_valid_q && iss_we_q && !iss_err_q;
    assign bus.mem_addr  = rst ? '0 : iss_addr_q;
    assign bus.mem_wdata = rst ? '0 : iss_wdata_q;

    logic          rsp_valid_q, rsp_port_q, rsp_err_q;
    logic [DW-1:0] rsp_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= iss_valid_q;
            rsp_port_q  <= iss_port_q;
            rsp_err_q   <= iss_valid_q && iss_err_q;
            rsp_rdata_q <= (iss_valid_q && !iss_we_q && !iss_err_q) ? bus.mem_rdata : '0;
        end
    end

    logic rv0, rv1;
    assign rv0 = !rst && rsp_valid_q && !rsp_port_q;
    assign rv1 = !rst && rsp_valid_q &&  rsp_port_q;

    assign bus.m0_rvalid = rv0;
    assign bus.m1_rvalid = rv1;
    assign bus.m0_err    = rv0 && rsp_err_q;
    assign bus.m1_err    = rv1 && rsp_err_q;
    assign bus.m0_rdata  = rv0 ? rsp_rdata_q : '0;
    assign bus.m1_rdata  = rv1 ? rsp_rdata_q : '0;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Scoreboard bench for dmem_arbiter with a behavioural memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;
    localparam int AW = 19, DW = 19, DEPTH = 1025, MAX_LOCK = 8;
    localparam logic [AW-1:0] C_DEPTH = AW'(DEPTH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem     [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    assign bus.mem_rdata = (bus.mem_addr < C_DEPTH) ? mem[bus.mem_addr[10:0]] : '0;
    always @(posedge clk)
        if (bus.mem_we && bus.mem_addr < C_DEPTH) mem[bus.mem_addr[10:0]] <= bus.mem_wdata;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic          gnt_log[$];
    int            cyc = 0;
    int            we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic record(input logic port, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        exp_t e;
        e.port = port;
        e.err  = (addr >= C_DEPTH);
        e.data = '0;
        e.due  = cyc + 2;
        if (!e.err) begin
            if (we) ref_mem[addr[10:0]] = wdata;
            else    e.data = ref_mem[addr[10:0]];
        end
        sb.push_back(e);
        gnt_log.push_back(port);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response checker and acceptance recorder
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                chk("rsp_missing", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            chk("rvalid_onehot", bus.m0_rvalid & bus.m1_rvalid, 0);
            chk("ready_onehot", bus.m0_ready & bus.m1_ready, 0);
            if (bus.m0_rvalid || bus.m1_rvalid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", bus.m0_rvalid | bus.m1_rvalid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_port", bus.m1_rvalid, e.port);
                    chk("rsp_data", bus.m1_rvalid ? bus.m1_rdata : bus.m0_rdata, e.data);
                    chk("rsp_err", bus.m1_rvalid ? bus.m1_err : bus.m0_err, e.err);
                    chk("rsp_cycle", cyc, e.due);
                end
            end
            if (bus.m0_valid && bus.m0_ready) record(1'b0, bus.m0_we, bus.m0_addr, bus.m0_wdata);
            if (bus.m1_valid && bus.m1_ready) record(1'b1, bus.m1_we, bus.m1_addr, bus.m1_wdata);
            if (bus.mem_we) begin
                we_cnt  = we_cnt + 1;
                we_addr = bus.mem_addr;
            end
        end
    end

    task automatic idle();
        bus.m0_valid = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_valid = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.m1_lock  = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic xfer(input logic port, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        logic done = 1'b0;
        int   n = 0;
        if (port) begin
            bus.m1_valid = 1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_valid = 1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
        while (!done && n < 50) begin
            @(negedge clk);
            done = port ? bus.m1_ready : bus.m0_ready;
            n++;
            step();
        end
        chk("xfer_accept", done, 1);
        if (port) bus.m1_valid = 0;
        else      bus.m0_valid = 0;
    endtask

    initial begin
        int m1_left;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'(i * 7 + 1);
            ref_mem[i] = DW'(i * 7 + 1);
        end
        idle();
        rst = 1;
        bus.m0_valid = 1;
        bus.m1_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_ready", bus.m0_ready, 0);
        chk("rst_m1_ready", bus.m1_ready, 0);
        chk("rst_m0_rvalid", bus.m0_rvalid, 0);
        chk("rst_m1_rvalid", bus.m1_rvalid, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.m0_rdata | bus.m1_rdata, 0);
        chk("rst_err", bus.m0_err | bus.m1_err, 0);
        step();
        rst = 0;
        idle();

        // Single read of addr 2 (holds 0xF)
        xfer(1'b0, 1'b0, 19'd2, '0);
        repeat (3) step();

        // Contention straight after reset
        rst = 1;
        step();
        rst = 0;
        gnt_log.delete();
        bus.m0_valid = 1; bus.m0_addr = 19'd4;
        bus.m1_valid = 1; bus.m1_addr = 19'd5;
        repeat (6) step();
        idle();
        repeat (3) step();
        chk("contend_count", gnt_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < gnt_log.size()) chk("contend_gnt", gnt_log[i], i % 2);

        // Write then read on m1
        we_cnt = 0;
        xfer(1'b1, 1'b1, 19'd10, 19'h12345);
        xfer(1'b1, 1'b0, 19'd10, '0);
        repeat (3) step();
        chk("raw_we_cnt", we_cnt, 1);
        chk("raw_we_addr", we_addr, 10);

        // Lock bound: last grant m0, then 12 locked m1 beats with m0 waiting
        xfer(1'b0, 1'b0, 19'd3, '0);
        gnt_log.delete();
        bus.m0_valid = 1; bus.m0_addr = 19'd3;
        m1_left = 12;
        for (int c = 0; c < 100 && m1_left > 0; c++) begin
            bus.m1_valid = 1; bus.m1_lock = 1; bus.m1_addr = AW'(32 + 12 - m1_left);
            @(negedge clk);
            if (bus.m1_ready) m1_left--;
            step();
        end
        chk("lock_done", m1_left, 0);
        idle();
        repeat (3) step();
        chk("lock_count", gnt_log.size(), 13);
        for (int i = 0; i < 13; i++)
            if (i < gnt_log.size()) chk("lock_gnt", gnt_log[i], (i == 8) ? 0 : 1);

        // Out of range and last valid address
        we_cnt = 0;
        xfer(1'b0, 1'b1, 19'd1025, 19'h7FFFF);
        xfer(1'b0, 1'b0, 19'd1025, '0);
        xfer(1'b1, 1'b0, 19'd1024, '0);
        repeat (3) step();
        chk("oor_we_cnt", we_cnt, 0);

        // Reset in the cycle after a read is accepted
        xfer(1'b0, 1'b0, 19'd6, '0);
        rst = 1;
        bus.m0_valid = 1;
        bus.m1_valid = 1;
        @(negedge clk);
        chk("midrst_m0_ready", bus.m0_ready, 0);
        chk("midrst_rvalid", bus.m0_rvalid | bus.m1_rvalid, 0);
        chk("midrst_mem_addr", bus.mem_addr, 0);
        chk("midrst_mem_we", bus.mem_we, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("post_rst_m0_ready", bus.m0_ready, 1);
        chk("post_rst_m1_ready", bus.m1_ready, 0);
        step();
        idle();
        repeat (4) step();
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
